// File: rtl/irq_pkg.sv
// Shared types and helpers for the external interrupt request controller.
package irq_pkg;

  // Default number of request sources; source 0 has the highest priority.
  localparam int NSRC_DEF = 3;

  // Width of a source index.
  localparam int IDX_W = (NSRC_DEF > 1) ? $clog2(NSRC_DEF) : 1;

  // Controller FSM states.
  //   IDLE  : nothing offered to CP0
  //   REQ   : one request offered, waiting for CP0 to take it
  //   SERVE : handler running, waiting for eret
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2
  } irq_state_e;

  // Index of the lowest set bit of v (0 when v is all-zero; callers only use
  // the result when v is non-zero).
  function automatic logic [IDX_W-1:0] prio_enc(input logic [NSRC_DEF-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NSRC_DEF - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One request line: two-flop synchroniser, a third delay flop, and a
// one-cycle rising-edge strobe taken from the synchronised value.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_out
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  // Shift the raw line through the synchroniser and delay stage.
  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchroniser and delay flops; cleared by reset so a line held high
  // through reset release yields exactly one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // Rising edge of the synchronised line, one cycle wide.
  assign edge_out = s2_q & ~s3_q;

endmodule

// File: rtl/irq_ctrl.sv
// External interrupt request controller. Latches synchronised rising edges
// as pending requests and offers at most one one-hot request to CP0 at a
// time, holding it until CP0 takes it and then staying quiet until eret.
//
// Handshake with CP0: exp_src is the request (registered, zero or one-hot).
// It stays stable while in REQ until either exp_ack is sampled high (request
// taken, pending bit cleared, handler in service) or exp_block is sampled
// high without exp_ack (request withdrawn, pending bit kept). exp_ack wins
// over exp_block. exp_ack outside REQ and eret outside SERVE are ignored.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NSRC = NSRC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic            exp_ack,
  input  logic            exp_block,
  input  logic            eret,
  output logic [NSRC-1:0] exp_src,
  output logic [NSRC-1:0] pending,
  output logic            busy,
  output logic [NSRC-1:0] overrun
);

  localparam logic [NSRC-1:0] ONE = NSRC'(1);

  // Per-source edge strobes from the synchronisers.
  logic [NSRC-1:0] edge_s;

  irq_state_e       state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [NSRC-1:0]  exp_src_q, exp_src_d;
  logic             busy_q, busy_d;
  logic [NSRC-1:0]  pending_q, pending_d;
  logic [NSRC-1:0]  overrun_q, overrun_d;
  logic [NSRC-1:0]  clr_mask;
  logic [IDX_W-1:0] pick;

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_sync
      irq_sync_edge u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (irq_in[g]),
        .edge_out (edge_s[g])
      );
    end
  endgenerate

  // Pending and overrun bookkeeping. An acknowledge clears the selected
  // pending bit, but an edge on the same source in the same cycle keeps it
  // set (the new request is not lost) and is not counted as an overrun.
  always_comb begin
    clr_mask = '0;
    if (state_q == REQ && exp_ack) clr_mask = ONE << sel_q;
    pending_d = (pending_q & ~clr_mask) | edge_s;
    overrun_d = overrun_q | (edge_s & pending_q & ~clr_mask);
  end

  // Next state, selected source and registered outputs of the request FSM.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    exp_src_d = exp_src_q;
    busy_d    = busy_q;
    pick      = prio_enc(pending_q);
    case (state_q)
      IDLE: begin
        exp_src_d = '0;
        busy_d    = 1'b0;
        if (pending_q != '0 && !exp_block) begin
          sel_d     = pick;
          exp_src_d = ONE << pick;
          state_d   = REQ;
        end
      end
      REQ: begin
        // sel is frozen here: a higher-priority edge waits its turn.
        if (exp_ack) begin
          exp_src_d = '0;
          busy_d    = 1'b1;
          state_d   = SERVE;
        end else if (exp_block) begin
          exp_src_d = '0;
          state_d   = IDLE;
        end
      end
      SERVE: begin
        // No nesting: new edges only accumulate in pending.
        exp_src_d = '0;
        if (eret) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        exp_src_d = '0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State, selection, bookkeeping and output registers; reset drops any
  // outstanding request immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      exp_src_q <= '0;
      busy_q    <= 1'b0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      exp_src_q <= exp_src_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign exp_src = exp_src_q;
  assign busy    = busy_q;
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_irq_ctrl;

  localparam int N = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] irq_in;
  logic         exp_ack, exp_block, eret;
  logic [N-1:0] exp_src, pending, overrun;
  logic         busy;

  irq_ctrl #(.NSRC(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .exp_ack   (exp_ack),
    .exp_block (exp_block),
    .eret      (eret),
    .exp_src   (exp_src),
    .pending   (pending),
    .busy      (busy),
    .overrun   (overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases of the CP0 conversation as seen from outside.
  localparam int WAITING    = 0;
  localparam int OFFERED    = 1;
  localparam int IN_SERVICE = 2;

  logic [N-1:0] hist[$];   // irq_in as sampled at each clock, newest first
  logic [N-1:0] m_pend, m_ovr, m_offer, rise, taken, next_pend;
  int           m_phase;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist = {};
      for (int i = 0; i < 4; i++) hist.push_back('0);
      m_pend  = '0;
      m_ovr   = '0;
      m_offer = '0;
      m_phase = WAITING;
    end else begin
      hist.push_front(irq_in);
      while (hist.size() > 4) void'(hist.pop_back());
      // A rise sampled two clocks ago becomes a request at this clock.
      rise  = hist[2] & ~hist[3];
      taken = (m_phase == OFFERED && exp_ack) ? m_offer : '0;
      m_ovr = m_ovr | (rise & m_pend & ~taken);
      next_pend = (m_pend & ~taken) | rise;
      case (m_phase)
        WAITING: if (m_pend != '0 && !exp_block) begin
          m_offer = m_pend & (~m_pend + 1'b1);   // lowest set bit
          m_phase = OFFERED;
        end
        OFFERED: begin
          if (exp_ack) m_phase = IN_SERVICE;
          else if (exp_block) m_phase = WAITING;
        end
        default: if (eret) m_phase = WAITING;
      endcase
      m_pend = next_pend;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("exp_src", exp_src, (m_phase == OFFERED) ? m_offer : '0);
      chk("busy",    busy,    m_phase == IN_SERVICE);
      chk("pending", pending, m_pend);
      chk("overrun", overrun, m_ovr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    exp_ack = 1'b1; step(1); exp_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1; step(1); eret = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; irq_in = '0; exp_ack = 1'b0; exp_block = 1'b0; eret = 1'b0;
    step(3);
    reset = 1'b0;
    chk("rst_exp_src", exp_src, 3'b000);
    chk("rst_pending", pending, 3'b000);
    chk("rst_busy",    busy,    1'b0);
    chk("rst_overrun", overrun, 3'b000);

    // Single request on source 1.
    irq_in = 3'b010;
    step(3);
    chk("single_not_yet", exp_src, 3'b000);
    chk("single_pending", pending, 3'b010);
    step(1);
    chk("single_exp_src", exp_src, 3'b010);
    pulse_ack();
    chk("single_ack_src",  exp_src, 3'b000);
    chk("single_ack_busy", busy,    1'b1);
    chk("single_ack_pend", pending, 3'b000);
    pulse_eret();
    chk("single_eret_busy", busy, 1'b0);
    irq_in = 3'b000; step(3);

    // Priority: sources 2 and 0 together.
    irq_in = 3'b101;
    step(4);
    chk("prio_first", exp_src, 3'b001);
    chk("prio_pend",  pending, 3'b101);
    pulse_ack();
    chk("prio_ack_pend", pending, 3'b100);
    pulse_eret();
    chk("prio_gap", exp_src, 3'b000);
    step(1);
    chk("prio_second", exp_src, 3'b100);
    pulse_ack(); pulse_eret();
    irq_in = 3'b000; step(3);

    // Blocking.
    exp_block = 1'b1;
    irq_in = 3'b001;
    step(5);
    chk("blk_pend", pending, 3'b001);
    chk("blk_src",  exp_src, 3'b000);
    exp_block = 1'b0; step(1);
    chk("blk_release", exp_src, 3'b001);
    exp_block = 1'b1; step(1);
    chk("blk_withdraw_src",  exp_src, 3'b000);
    chk("blk_withdraw_pend", pending, 3'b001);
    exp_block = 1'b0; step(1);
    chk("blk_reoffer", exp_src, 3'b001);
    pulse_ack(); pulse_eret();
    irq_in = 3'b000; step(3);

    // Overrun while in service.
    irq_in = 3'b010; step(4);
    chk("ovr_req", exp_src, 3'b010);
    pulse_ack();
    irq_in = 3'b110; step(2);
    irq_in = 3'b010; step(2);
    irq_in = 3'b110; step(2);
    irq_in = 3'b010; step(4);
    chk("ovr_pend", pending, 3'b100);
    chk("ovr_flag", overrun, 3'b100);
    chk("ovr_busy", busy,    1'b1);
    pulse_eret(); step(1);
    chk("ovr_next", exp_src, 3'b100);
    pulse_ack(); pulse_eret();
    irq_in = 3'b000; step(3);

    // Asynchronous reset in the middle of a request.
    irq_in = 3'b010; step(4);
    chk("mid_req_src", exp_src, 3'b010);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_src",  exp_src, 3'b000);
    chk("async_rst_pend", pending, 3'b000);
    chk("async_rst_ovr",  overrun, 3'b000);
    step(2);
    reset = 1'b0;
    step(1);
    chk("post_rst_idle", exp_src, 3'b000);
    step(3);
    chk("held_line_edge", exp_src, 3'b010);
    pulse_ack(); pulse_eret();
    chk("held_line_once", pending, 3'b000);

    // Edge on the in-service source in the same cycle as the acknowledge.
    irq_in = 3'b110; step(4);
    chk("same_req", exp_src, 3'b100);
    irq_in = 3'b010; step(2);
    irq_in = 3'b110; step(2);
    exp_ack = 1'b1; step(1); exp_ack = 1'b0;
    chk("same_pend", pending, 3'b100);
    chk("same_ovr",  overrun, 3'b000);
    chk("same_busy", busy,    1'b1);
    pulse_eret(); step(1);
    chk("same_reoffer", exp_src, 3'b100);
    pulse_ack(); pulse_eret();
    irq_in = 3'b000; step(4);

    // Randomized traffic; request lines change only every second cycle.
    for (int c = 0; c < 3000; c++) begin
      if (c % 2 == 0) irq_in = N'($urandom_range(0, 7));
      exp_ack   = ($urandom_range(0, 3) == 0);
      eret      = ($urandom_range(0, 5) == 0);
      exp_block = ($urandom_range(0, 9) == 0);
      step(1);
    end
    irq_in = '0; exp_ack = 1'b0; eret = 1'b0; exp_block = 1'b0;
    step(6);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
